// File: rtl/regymm_edgeburst_gen.sv
// Programmable edge-burst generator: N level toggles on sig1/sig2, in-phase or quadrature-lagged.
// Optional auto-repeat of a completed burst is enabled by defining EDGEBURST_REPEAT_EN.
module regymm_edgeburst_gen #(
   parameter int CNT_W = 14,
   parameter int DIV_W = 8
) (
   input  logic             clk25,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] burst_len,
   input  logic [DIV_W-1:0] half_period,
   input  logic [1:0]       ch_mask,
   input  logic             phase90,
`ifdef EDGEBURST_REPEAT_EN
   input  logic             repeat_burst,
`endif
   output logic             sig1,
   output logic             sig2,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sent
);

   typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

   state_t           state, state_n;
   logic [DIV_W-1:0] div, div_n;
   logic [DIV_W-1:0] lcnt, lcnt_n;
   logic [CNT_W-1:0] cfg_len, cfg_len_n;
   logic [DIV_W-1:0] cfg_hp, cfg_hp_n;
   logic [1:0]       cfg_mask, cfg_mask_n;
   logic             cfg_ph, cfg_ph_n;
   logic             rearm, rearm_n;
   logic             sig1_n, sig2_n, busy_n, done_n;
   logic [CNT_W-1:0] sent_n;

   logic [DIV_W-1:0] hp_in_eff;
   logic [DIV_W-1:0] lag_eff;
   logic             rpt;
   logic             finish;

   assign hp_in_eff = (half_period == '0) ? DIV_W'(1) : half_period;
   assign lag_eff   = (cfg_hp > DIV_W'(1)) ? (cfg_hp >> 1) : DIV_W'(1);

`ifdef EDGEBURST_REPEAT_EN
   assign rpt = repeat_burst;
`else
   assign rpt = 1'b0;
`endif

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n    = state;
      div_n      = div;
      lcnt_n     = lcnt;
      cfg_len_n  = cfg_len;
      cfg_hp_n   = cfg_hp;
      cfg_mask_n = cfg_mask;
      cfg_ph_n   = cfg_ph;
      rearm_n    = 1'b0;
      sig1_n     = sig1;
      sig2_n     = sig2;
      busy_n     = busy;
      done_n     = 1'b0;
      sent_n     = rearm ? '0 : sent;
      finish     = 1'b0;

      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (burst_len != '0) begin
                  cfg_len_n  = burst_len;
                  cfg_hp_n   = hp_in_eff;
                  cfg_mask_n = ch_mask;
                  cfg_ph_n   = phase90;
                  sent_n     = '0;
                  div_n      = hp_in_eff;
                  lcnt_n     = '0;
                  busy_n     = 1'b1;
                  state_n    = RUN;
               end else begin
                  done_n = 1'b1;
               end
            end
         end

         RUN: begin
            if (abort) begin
               sent_n  = sent;
               lcnt_n  = '0;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               div_n  = div - DIV_W'(1);
               lcnt_n = (lcnt != '0) ? lcnt - DIV_W'(1) : '0;
               if (lcnt == DIV_W'(1) && cfg_mask[1])
                  sig2_n = ~sig2;
               if (div == DIV_W'(1)) begin
                  div_n  = cfg_hp;
                  sent_n = (rearm ? '0 : sent) + CNT_W'(1);
                  if (cfg_mask[0])
                     sig1_n = ~sig1;
                  if (cfg_ph)
                     lcnt_n = lag_eff;
                  else if (cfg_mask[1])
                     sig2_n = ~sig2;
                  if (sent_n == cfg_len) begin
                     if (cfg_ph) state_n = TAIL;
                     else        finish  = 1'b1;
                  end
               end
            end
         end

         TAIL: begin
            if (abort) begin
               sent_n  = sent;
               lcnt_n  = '0;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               lcnt_n = (lcnt != '0) ? lcnt - DIV_W'(1) : '0;
               if (lcnt == DIV_W'(1)) begin
                  if (cfg_mask[1])
                     sig2_n = ~sig2;
                  finish = 1'b1;
               end
            end
         end

         default: state_n = IDLE;
      endcase

      // A completed burst either returns to IDLE or re-arms with the latched config.
      if (finish) begin
         done_n = 1'b1;
         if (rpt) begin
            state_n = RUN;
            div_n   = cfg_hp;
            lcnt_n  = '0;
            rearm_n = 1'b1;
         end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         div      <= '0;
         lcnt     <= '0;
         cfg_len  <= '0;
         cfg_hp   <= '0;
         cfg_mask <= '0;
         cfg_ph   <= 1'b0;
         rearm    <= 1'b0;
         sig1     <= 1'b0;
         sig2     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sent     <= '0;
      end else begin
         state    <= state_n;
         div      <= div_n;
         lcnt     <= lcnt_n;
         cfg_len  <= cfg_len_n;
         cfg_hp   <= cfg_hp_n;
         cfg_mask <= cfg_mask_n;
         cfg_ph   <= cfg_ph_n;
         rearm    <= rearm_n;
         sig1     <= sig1_n;
         sig2     <= sig2_n;
         busy     <= busy_n;
         done     <= done_n;
         sent     <= sent_n;
      end
   end

endmodule

// File: tb/tb_regymm_edgeburst_gen.sv
// Directed bench for regymm_edgeburst_gen: per-edge expected toggle, busy and done
// patterns written out by hand as bit vectors (bit k = state after edge k).
module tb_regymm_edgeburst_gen;

   localparam int CNT_W = 14;
   localparam int DIV_W = 8;

   logic             clk25 = 1'b0;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] burst_len;
   logic [DIV_W-1:0] half_period;
   logic [1:0]       ch_mask;
   logic             phase90;
`ifdef EDGEBURST_REPEAT_EN
   logic             repeat_burst;
`endif
   logic             sig1, sig2, busy, done;
   logic [CNT_W-1:0] sent;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp1  = 1'b0;
   logic exp2  = 1'b0;

   regymm_edgeburst_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .burst_len   (burst_len),
      .half_period (half_period),
      .ch_mask     (ch_mask),
      .phase90     (phase90),
`ifdef EDGEBURST_REPEAT_EN
      .repeat_burst(repeat_burst),
`endif
      .sig1        (sig1),
      .sig2        (sig2),
      .busy        (busy),
      .done        (done),
      .sent        (sent)
   );

   always #5 clk25 = ~clk25;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // One rising edge, then park on the falling edge for sampling and driving.
   task automatic step();
      @(posedge clk25);
      @(negedge clk25);
   endtask

   // Start a burst at e0 and check sig1/sig2/busy/done after each edge up to n.
   task automatic run_burst(input string tag, input int len, input int hp,
                            input logic [1:0] mask, input logic ph, input int n,
                            input logic [31:0] t1, input logic [31:0] t2,
                            input logic [31:0] bz, input logic [31:0] dn,
                            input int abort_at, input int restart_at, input int rpt_off);
      burst_len   = CNT_W'(len);
      half_period = DIV_W'(hp);
      ch_mask     = mask;
      phase90     = ph;
      start       = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("%s busy e0", tag), 32'(busy), 32'(bz[0]));
      check($sformatf("%s done e0", tag), 32'(done), 32'(dn[0]));
      for (int k = 1; k <= n; k++) begin
         if (k == restart_at) begin
            burst_len   = CNT_W'(1);
            half_period = DIV_W'(7);
            ch_mask     = 2'b00;
            start       = 1'b1;
         end
         abort = (k == abort_at);
`ifdef EDGEBURST_REPEAT_EN
         if (k == rpt_off) repeat_burst = 1'b0;
`endif
         step();
         start = 1'b0;
         abort = 1'b0;
         if (t1[k]) exp1 = ~exp1;
         if (t2[k]) exp2 = ~exp2;
         check($sformatf("%s sig1 e%0d", tag, k), 32'(sig1), 32'(exp1));
         check($sformatf("%s sig2 e%0d", tag, k), 32'(sig2), 32'(exp2));
         check($sformatf("%s busy e%0d", tag, k), 32'(busy), 32'(bz[k]));
         check($sformatf("%s done e%0d", tag, k), 32'(done), 32'(dn[k]));
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      burst_len   = '0;
      half_period = '0;
      ch_mask     = 2'b00;
      phase90     = 1'b0;
`ifdef EDGEBURST_REPEAT_EN
      repeat_burst = 1'b0;
`endif
      #12;
      check("reset sig1", 32'(sig1), 32'd0);
      check("reset sig2", 32'(sig2), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset sent", 32'(sent), 32'd0);
      @(negedge clk25);
      rst_n = 1'b1;
      step();

      // In-phase burst; a second start at e5 with different config must be ignored.
      run_burst("t1", 5, 3, 2'b11, 1'b0, 17, 32'h9248, 32'h9248, 32'h7FFF, 32'h8000, 0, 5, 0);
      check("t1 sent", 32'(sent), 32'd5);

      // Async reset mid-burst from levels 1,1: toggles at e2,e4 leave both at 1.
      burst_len = CNT_W'(8); half_period = DIV_W'(2); ch_mask = 2'b11; phase90 = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      check("t5 pre sig1", 32'(sig1), 32'd1);
      check("t5 pre busy", 32'(busy), 32'd1);
      check("t5 pre sent", 32'(sent), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("t5 rst sig1", 32'(sig1), 32'd0);
      check("t5 rst sig2", 32'(sig2), 32'd0);
      check("t5 rst busy", 32'(busy), 32'd0);
      check("t5 rst sent", 32'(sent), 32'd0);
      check("t5 rst done", 32'(done), 32'd0);
      @(negedge clk25);
      rst_n = 1'b1;
      exp1 = 1'b0;
      exp2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("t5 idle busy %0d", k), 32'(busy), 32'd0);
         check($sformatf("t5 idle sig1 %0d", k), 32'(sig1), 32'd0);
      end

      // Quadrature: sig1 at e4,8,12; sig2 lags by 2 at e6,10,14; done only at e14.
      run_burst("t2", 3, 4, 2'b11, 1'b1, 16, 32'h1110, 32'h4440, 32'h3FFF, 32'h4000, 0, 0, 0);
      check("t2 sent", 32'(sent), 32'd3);

      // Abort at e7 after slots at e3,e6: no done, sent and levels held.
      run_burst("t3", 10, 3, 2'b11, 1'b0, 10, 32'h48, 32'h48, 32'h7F, 32'h0, 7, 0, 0);
      check("t3 sent", 32'(sent), 32'd2);

      // Zero-length burst: done pulse at e0 only, never busy, levels unchanged.
      run_burst("t4", 0, 3, 2'b11, 1'b0, 4, 32'h0, 32'h0, 32'h0, 32'h1, 0, 0, 0);

`ifdef EDGEBURST_REPEAT_EN
      // Repeat: slots at e2,4,6,8; done at e4 and e8; repeat dropped before e8.
      repeat_burst = 1'b1;
      run_burst("t6", 2, 2, 2'b11, 1'b0, 10, 32'h154, 32'h154, 32'hFF, 32'h110, 0, 0, 6);
      check("t6 sent", 32'(sent), 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
